// File: rtl/gray_rx_if.sv
// Gray counter bus between the counter (master) and the receiving monitor (slave).
interface gray_rx_if #(
    parameter int unsigned SIZE  = 3,
    parameter int unsigned CNT_W = 8
);
    logic [SIZE-1:0]  gray_in;
    logic             valid_in;
    logic [SIZE-1:0]  bin_out;
    logic             bin_valid;
    logic             wrap;
    logic             err;
    logic             locked;
    logic [CNT_W-1:0] err_count;

    modport master (
        output gray_in, valid_in,
        input  bin_out, bin_valid, wrap, err, locked, err_count
    );

    modport slave (
        input  gray_in, valid_in,
        output bin_out, bin_valid, wrap, err, locked, err_count
    );
endinterface

// File: rtl/gray_rx_monitor.sv
// Gray-to-binary receiver that tracks the +1 Gray sequence, reports lock,
// wrap events and sequence errors with a saturating error count.
module gray_rx_monitor #(
    parameter int unsigned SIZE     = 3,
    parameter int unsigned LOCK_RUN = 4,
    parameter int unsigned CNT_W    = 8
) (
    input logic      clk,
    input logic      reset,
    gray_rx_if.slave bus
);
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t           state_q, state_n;
    logic [SIZE-1:0]  ref_q, ref_n;
    logic [RUN_W-1:0] run_q, run_n;
    logic [SIZE-1:0]  bin_n;
    logic             bin_valid_n, wrap_n, err_n;
    logic [CNT_W-1:0] cnt_n;

    logic [SIZE-1:0]  dec;
    logic [SIZE-1:0]  ref_inc;
    logic [RUN_W-1:0] run_inc;
    logic             good, hold;

    // Each binary bit is the XOR of the Gray bits at and above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            dec[i] = ^(bus.gray_in >> i);
        end
    end

    assign ref_inc = ref_q + SIZE'(1);
    assign run_inc = run_q + RUN_W'(1);
    assign good    = (dec == ref_inc);
    assign hold    = (dec == ref_q);

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_q;
        ref_n       = ref_q;
        run_n       = run_q;
        bin_n       = bus.bin_out;
        bin_valid_n = 1'b0;
        wrap_n      = 1'b0;
        err_n       = 1'b0;
        cnt_n       = bus.err_count;
        if (bus.valid_in) begin
            bin_n       = dec;
            bin_valid_n = 1'b1;
            case (state_q)
                IDLE: begin
                    ref_n   = dec;
                    run_n   = '0;
                    state_n = TRACK;
                end
                TRACK: begin
                    if (good) begin
                        ref_n = dec;
                        run_n = run_inc;
                        if (run_inc == RUN_W'(LOCK_RUN)) begin
                            state_n = LOCKED;
                        end
                    end else if (!hold) begin
                        ref_n = dec;
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        ref_n  = dec;
                        wrap_n = (ref_q == '1) && (dec == '0);
                    end else if (!hold) begin
                        err_n   = 1'b1;
                        ref_n   = dec;
                        run_n   = '0;
                        state_n = TRACK;
                        if (bus.err_count != '1) begin
                            cnt_n = bus.err_count + CNT_W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ref_q         <= '0;
            run_q         <= '0;
            bus.bin_out   <= '0;
            bus.bin_valid <= 1'b0;
            bus.wrap      <= 1'b0;
            bus.err       <= 1'b0;
            bus.locked    <= 1'b0;
            bus.err_count <= '0;
        end else begin
            state_q       <= state_n;
            ref_q         <= ref_n;
            run_q         <= run_n;
            bus.bin_out   <= bin_n;
            bus.bin_valid <= bin_valid_n;
            bus.wrap      <= wrap_n;
            bus.err       <= err_n;
            bus.locked    <= (state_n == LOCKED);
            bus.err_count <= cnt_n;
        end
    end
endmodule

// File: tb/tb_gray_rx_monitor.sv
// Scoreboard bench for gray_rx_monitor: an 8-bit-count and a 2-bit-count
// instance share one directed stimulus stream.
module tb_gray_rx_monitor;
    logic clk;
    logic reset;

    gray_rx_if #(.SIZE(3), .CNT_W(8)) bus_a ();
    gray_rx_if #(.SIZE(3), .CNT_W(2)) bus_b ();

    assign bus_b.gray_in  = bus_a.gray_in;
    assign bus_b.valid_in = bus_a.valid_in;

    gray_rx_monitor #(.SIZE(3), .LOCK_RUN(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    gray_rx_monitor #(.SIZE(3), .LOCK_RUN(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] bin;
        logic       wrap;
        logic       err;
        logic       locked;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] to_gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic send(input logic [2:0] g, input logic [2:0] b, input logic w,
                        input logic e, input logic l, input logic [7:0] c);
        exp_t x;
        @(negedge clk);
        bus_a.gray_in  = g;
        bus_a.valid_in = 1'b1;
        x.bin = b; x.wrap = w; x.err = e; x.locked = l; x.cnt = c;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_a.valid_in = 1'b0;
        end
    endtask

    task automatic sync_reset();
        @(negedge clk);
        bus_a.valid_in = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_bin_a"},    32'(bus_a.bin_out),   0);
        chk({tag, "_vld_a"},    32'(bus_a.bin_valid), 0);
        chk({tag, "_wrap_a"},   32'(bus_a.wrap),      0);
        chk({tag, "_err_a"},    32'(bus_a.err),       0);
        chk({tag, "_locked_a"}, 32'(bus_a.locked),    0);
        chk({tag, "_cnt_a"},    32'(bus_a.err_count), 0);
        chk({tag, "_locked_b"}, 32'(bus_b.locked),    0);
        chk({tag, "_cnt_b"},    32'(bus_b.err_count), 0);
    endtask

    // Monitor: pop one expectation per presented sample, otherwise pulses must be low.
    always @(posedge clk) begin
        exp_t x;
        #1;
        chk("vld_match_b", 32'(bus_b.bin_valid), 32'(bus_a.bin_valid));
        if (bus_a.bin_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bin_valid got bin %0d expected no sample", bus_a.bin_out);
            end else begin
                x = q.pop_front();
                chk("bin_a",    32'(bus_a.bin_out),   32'(x.bin));
                chk("wrap_a",   32'(bus_a.wrap),      32'(x.wrap));
                chk("err_a",    32'(bus_a.err),       32'(x.err));
                chk("locked_a", 32'(bus_a.locked),    32'(x.locked));
                chk("cnt_a",    32'(bus_a.err_count), 32'(x.cnt));
                chk("bin_b",    32'(bus_b.bin_out),   32'(x.bin));
                chk("wrap_b",   32'(bus_b.wrap),      32'(x.wrap));
                chk("err_b",    32'(bus_b.err),       32'(x.err));
                chk("locked_b", 32'(bus_b.locked),    32'(x.locked));
                chk("cnt_b",    32'(bus_b.err_count), (x.cnt > 8'd3) ? 32'd3 : 32'(x.cnt));
            end
        end else begin
            chk("pulse_idle_a", 32'(bus_a.wrap | bus_a.err), 0);
            chk("pulse_idle_b", 32'(bus_b.wrap | bus_b.err), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] r;
        reset = 1'b1;
        bus_a.gray_in  = '0;
        bus_a.valid_in = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("init");
        reset = 1'b0;

        // Full ascending stream: lock after bin 4, wrap on 7->0.
        send(3'b000, 0, 0, 0, 0, 0);
        send(3'b001, 1, 0, 0, 0, 0);
        send(3'b011, 2, 0, 0, 0, 0);
        send(3'b010, 3, 0, 0, 0, 0);
        send(3'b110, 4, 0, 0, 1, 0);
        send(3'b111, 5, 0, 0, 1, 0);
        send(3'b101, 6, 0, 0, 1, 0);
        send(3'b100, 7, 0, 0, 1, 0);
        send(3'b000, 0, 1, 0, 1, 0);
        // Jump 2->6 while locked, then relock through 7->0 without wrap.
        send(3'b001, 1, 0, 0, 1, 0);
        send(3'b011, 2, 0, 0, 1, 0);
        send(3'b101, 6, 0, 1, 0, 1);
        send(3'b100, 7, 0, 0, 0, 1);
        send(3'b000, 0, 0, 0, 0, 1);
        send(3'b001, 1, 0, 0, 0, 1);
        send(3'b011, 2, 0, 0, 1, 1);
        // Hold at bin 3 with a valid gap.
        send(3'b010, 3, 0, 0, 1, 1);
        send(3'b010, 3, 0, 0, 1, 1);
        idle(2);
        send(3'b010, 3, 0, 0, 1, 1);
        send(3'b010, 3, 0, 0, 1, 1);
        // Second error and relock, leaving err_count = 2.
        send(3'b101, 6, 0, 1, 0, 2);
        send(3'b100, 7, 0, 0, 0, 2);
        send(3'b000, 0, 0, 0, 0, 2);
        send(3'b001, 1, 0, 0, 0, 2);
        send(3'b011, 2, 0, 0, 1, 2);

        // Asynchronous reset between edges while locked.
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_cleared("async");
        @(negedge clk);
        bus_a.valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        send(3'b111, 5, 0, 0, 0, 0);
        send(3'b101, 6, 0, 0, 0, 0);
        send(3'b100, 7, 0, 0, 0, 0);
        send(3'b000, 0, 0, 0, 0, 0);
        send(3'b001, 1, 0, 0, 1, 0);

        // Bad steps while tracking never raise err.
        sync_reset();
        send(3'b000, 0, 0, 0, 0, 0);
        send(3'b111, 5, 0, 0, 0, 0);
        send(3'b011, 2, 0, 0, 0, 0);
        send(3'b100, 7, 0, 0, 0, 0);

        // Relock, then five errors each followed by a relock.
        send(3'b000, 0, 0, 0, 0, 0);
        send(3'b001, 1, 0, 0, 0, 0);
        send(3'b011, 2, 0, 0, 0, 0);
        send(3'b010, 3, 0, 0, 1, 0);
        r = 3'd3;
        for (int k = 1; k <= 5; k++) begin
            r = r + 3'd3;
            send(to_gray(r), r, 0, 1, 0, 8'(k));
            for (int j = 1; j <= 4; j++) begin
                r = r + 3'd1;
                send(to_gray(r), r, 0, 0, (j == 4), 8'(k));
            end
        end

        idle(4);
        chk("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
